// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: HH:MM:SS.cc BCD counter with start/stop/lap/clear control,
// producing registered display and digit-enable words for an 8-digit 7-seg driver.

// One BCD digit of the chain: advances on carry_in, wraps to 0 past LIMIT.
module bcd_digit #(
    parameter logic [3:0] LIMIT = 4'd9
) (
    input  logic [3:0] value,
    input  logic       carry_in,
    output logic [3:0] next
);
    always_comb begin
        next = value;
        if (carry_in)
            next = (value >= LIMIT) ? 4'd0 : value + 4'd1;
    end
endmodule

module stopwatch_ctrl #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int TICK_HZ    = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [31:0] display,
    output logic [7:0]  digit_enable,
    output logic        running,
    output logic        lap_active
);
    localparam int DIV        = CLOCK_FREQ / TICK_HZ;
    localparam int PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int NUM_DIGITS = 8;
    // Per-digit upper limit, digit 7 (hour tens) first.
    localparam logic [NUM_DIGITS-1:0][3:0] LIMITS =
        {4'd9, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STOP     = 3'd2,
        LAP_RUN  = 3'd3,
        LAP_STOP = 3'd4
    } state_t;

    state_t                         state, state_next;
    logic   [PW-1:0]                presc;
    logic   [31:0]                  count;
    logic   [31:0]                  snap;
    logic   [31:0]                  shown;
    logic   [NUM_DIGITS-1:0][3:0]   count_next;
    logic   [NUM_DIGITS-1:0]        carry;
    logic                           counting;
    logic                           lap_mode;
    logic                           tick;
    logic                           snap_en;
    logic                           zero_count;

    assign counting = (state == RUN) || (state == LAP_RUN);
    assign lap_mode = (state == LAP_RUN) || (state == LAP_STOP);
    assign tick     = counting && (presc == PW'(DIV - 1));
    assign carry[0] = tick;

    // Ripple carry: a digit advances only when every lower digit wraps.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit #(.LIMIT(LIMITS[i])) u_digit (
            .value    (count[4*i +: 4]),
            .carry_in (carry[i]),
            .next     (count_next[i])
        );
        if (i < NUM_DIGITS - 1) begin : g_carry
            assign carry[i+1] = carry[i] && (count[4*i +: 4] >= LIMITS[i]);
        end
    end

    // Each state checks buttons in clear > start_stop > lap order, skipping
    // buttons that are no-ops there, so only one event is ever taken.
    always_comb begin
        state_next = state;
        snap_en    = 1'b0;
        zero_count = 1'b0;
        case (state)
            IDLE: begin
                if (btn_start_stop) state_next = RUN;
            end
            RUN: begin
                if (btn_start_stop) begin
                    state_next = STOP;
                end else if (btn_lap) begin
                    state_next = LAP_RUN;
                    snap_en    = 1'b1;
                end
            end
            STOP: begin
                if (btn_clear) begin
                    state_next = IDLE;
                    zero_count = 1'b1;
                end else if (btn_start_stop) begin
                    state_next = RUN;
                end
            end
            LAP_RUN: begin
                if (btn_clear)           state_next = RUN;
                else if (btn_start_stop) state_next = LAP_STOP;
                else if (btn_lap)        snap_en    = 1'b1;
            end
            LAP_STOP: begin
                if (btn_clear)           state_next = STOP;
                else if (btn_start_stop) state_next = LAP_RUN;
                else if (btn_lap)        state_next = STOP;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Prescaler only moves while counting so a pause keeps the sub-tick phase.
    always_ff @(posedge clk) begin
        if (reset || zero_count) presc <= '0;
        else if (tick)           presc <= '0;
        else if (counting)       presc <= presc + 1'b1;
    end

    // Snapshot reads count before this cycle's increment lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            snap  <= '0;
        end else begin
            if (zero_count) count <= '0;
            else if (tick)  count <= count_next;
            if (snap_en)    snap  <= count;
        end
    end

    assign shown = lap_mode ? snap : count;

    always_ff @(posedge clk) begin
        if (reset) begin
            display      <= '0;
            digit_enable <= 8'h1F;
            running      <= 1'b0;
            lap_active   <= 1'b0;
        end else begin
            display      <= shown;
            digit_enable <= {shown[31:28] != 4'd0,
                             shown[31:24] != 8'd0,
                             (shown[23:20] != 4'd0) || (shown[31:24] != 8'd0),
                             5'h1F};
            running      <= counting;
            lap_active   <= lap_mode;
        end
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Stopwatch sequencer feeding the 8-digit seven-segment driver.
- Keeps an 8-digit BCD elapsed-time count in HH:MM:SS.cc form.
- Runs a start/stop/lap/clear state machine from single-cycle button pulses.
- Drives the driver's display[31:0] and digit_enable[7:0] inputs, with leading-zero blanking and a lap-freeze mode.
- Button pulses arrive already debounced and edge-detected upstream.

Parameters:
CLOCK_FREQ, 100000000, clk frequency in Hz
TICK_HZ, 100, count rate in Hz (one tick = 1/100 s); CLOCK_FREQ/TICK_HZ must be an integer ≥ 2

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
btn_start_stop  input  1  one-cycle pulse: toggle run/stop
btn_lap  input  1  one-cycle pulse: capture/release lap display
btn_clear  input  1  one-cycle pulse: zero the count or release lap
display  output  32  BCD digits to the driver; [3:0] hundredths ones, [7:4] hundredths tens, [11:8] sec ones, [15:12] sec tens, [19:16] min ones, [23:20] min tens, [27:24] hr ones, [31:28] hr tens
digit_enable  output  8  per-digit enable to the driver, bit n = digit n
running  output  1  1 in RUN or LAP_RUN
lap_active  output  1  1 in LAP_RUN or LAP_STOP

Behaviour:
- Reset (synchronous, active-high; wins over everything, including mid-count):
  - state = IDLE; live count, snapshot and prescaler = 0.
  - display = 32'h0; digit_enable = 8'h1F; running = 0; lap_active = 0.
- Prescaler:
  - Counts 0 .. CLOCK_FREQ/TICK_HZ-1 only while state is RUN or LAP_RUN.
  - On reaching terminal value: wraps to 0 and asserts an internal tick for one cycle.
  - Holds its value in STOP and LAP_STOP, so sub-tick phase is preserved across pause/resume.
  - Forced to 0 on entry to IDLE.
- BCD chain (updated on tick):
  - Hundredths 00-99, seconds 00-59, minutes 00-59, hours 00-99.
  - Each digit carries into the next at its limit.
  - 99:59:59.99 plus one tick becomes 00:00:00.00. No overflow flag; keeps running.
  - No digit ever holds a value > 9; tens-of-seconds/minutes never > 5.
- Event priority: at most one button acted on per cycle, in the order btn_clear > btn_start_stop > btn_lap. Lower-priority pulses in the same cycle are dropped.
- State machine:
  - IDLE: start_stop → RUN. lap and clear are no-ops.
  - RUN: start_stop → STOP. lap → LAP_RUN, snapshot ← live count. clear is a no-op.
  - STOP: start_stop → RUN. clear → IDLE, live count and prescaler zeroed. lap is a no-op.
  - LAP_RUN:
    - lap → stay in LAP_RUN, snapshot ← live count (new split).
    - start_stop → LAP_STOP.
    - clear → RUN (release lap, live count unaffected).
  - LAP_STOP: start_stop → LAP_RUN. lap → STOP (release). clear → STOP (release).
  - The live count keeps ticking in LAP_RUN.
  - A tick and a snapshot in the same cycle: the snapshot takes the pre-increment value.
- Outputs (all registered, one cycle after the state/count update):
  - display = snapshot when lap_active, else live count.
  - digit_enable is computed from the value being displayed:
    - bits 0-4 always 1;
    - bit 5 = (min tens ≠ 0) or (hours ≠ 0);
    - bit 6 = (hours ≠ 0);
    - bit 7 = (hr tens ≠ 0).
  - running and lap_active are decoded from the registered state.

Test Plan:
1. Bench: CLOCK_FREQ=1000, TICK_HZ=100 (10 clk/tick). Reset 3 cycles, pulse start_stop, wait 1000 clk → display=32'h0000_0100, digit_enable=8'h1F, running=1.
2. Preload near wrap via long run (or force-free sim at 10 clk/tick): run to 00:59:59.99 then 1 tick → display=32'h0100_0000, digit_enable=8'h7F. Run to 99:59:59.99 then 1 tick → display=32'h0, digit_enable=8'h1F.
3. Start, after 50 ticks pulse lap → display frozen at 32'h0000_0050, lap_active=1. After 30 more ticks pulse clear → display=32'h0000_0080, lap_active=0, running=1.
4. Start, stop at prescaler=7 mid-tick, wait 500 clk, start again → display unchanged while stopped; next tick arrives exactly 3 clk after restart.
5. In RUN, pulse start_stop, lap and clear in the same cycle → state STOP only, no snapshot, count not zeroed. Then pulse clear → display=0, running=0, state IDLE.
6. Assert reset while in LAP_RUN at 00:00:12.34 → next cycle display=0, digit_enable=8'h1F, running=0, lap_active=0. A subsequent start counts from 00:00:00.00.
